// File: rtl/iobus_uart_tx_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_pkg
// Shared types and constants for the IOBUS UART transmitter:
//   tx_state_t        serializer state encoding
//   DATA_OFS/STATUS_OFS  register byte offsets from BASE_ADDR
//   ST_*              bit positions inside the STATUS word
// ----------------------------------------------------------------------------
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [31:0] DATA_OFS   = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_ACTIVE  = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_MSB = 8;

endpackage

// File: rtl/iobus_uart_tx_byte_fifo.sv
// ----------------------------------------------------------------------------
// byte_fifo
// Synchronous first-word-fall-through byte FIFO.
//   CLK, RST_N  clock / asynchronous active-low reset
//   push, din   write strobe and data; a push while full is accepted only
//               when a pop happens on the same edge
//   pop, dout   read strobe; dout always shows the head entry
//   full, empty, count  occupancy flags and entry count (0..DEPTH)
// ----------------------------------------------------------------------------
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this push needs, so full does not block it.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;   // DEPTH is a power of two:
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;   // natural wrap is modulo DEPTH
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/iobus_uart_tx.sv
// ----------------------------------------------------------------------------
// iobus_uart_tx
// Memory-mapped 8N1 UART transmitter on the OTTER IOBUS.
//   CLK, RST_N   clock / asynchronous active-low reset
//   IOBUS_ADDR   CPU address; DATA at BASE_ADDR, STATUS at BASE_ADDR+4
//   IOBUS_OUT    CPU write data, byte [7:0] pushed on a DATA store
//   IOBUS_WR     one-cycle store strobe
//   IOBUS_IN     registered read data (STATUS word or zero)
//   TX           serial line, idle high
//   TX_BUSY      registered: frame in progress or bytes queued
// STATUS: [0] full, [1] empty, [2] tx_active, [3] overflow, [8:4] count.
// ----------------------------------------------------------------------------
module iobus_uart_tx
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX,
  output logic        TX_BUSY
);

  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] DATA_ADDR   = BASE_ADDR + DATA_OFS;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;
  localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);

  // Only the low byte of write data is transmitted.
  logic        unused_wdata;
  assign unused_wdata = ^IOBUS_OUT[31:8];

  logic          push, pop, status_hit, status_rd, drop;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  tx_state_t   state_q;
  logic [15:0] baud_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        baud_last;

  logic        overflow_q;
  logic        busy_q;
  logic [31:0] iobus_in_q;
  logic [31:0] status_w;

  assign push       = IOBUS_WR && (IOBUS_ADDR == DATA_ADDR);
  assign status_hit = (IOBUS_ADDR == STATUS_ADDR);
  assign status_rd  = status_hit && !IOBUS_WR;
  assign baud_last  = (baud_cnt_q == BAUD_LAST);

  // The serializer takes a byte either from IDLE or at the very end of STOP,
  // which gives back-to-back frames with no idle gap.
  assign pop  = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_last));
  assign drop = push && fifo_full && !pop;

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (push),
    .din   (IOBUS_OUT[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Serializer. TX is registered from the current state, so the line
  // trails the state by one cycle but every bit still lasts CLKS_PER_BIT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift_q[0];
        default: tx_q <= 1'b1;
      endcase

      case (state_q)
        IDLE: begin
          baud_cnt_q <= '0;
          if (pop) begin
            shift_q <= fifo_dout;
            state_q <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            state_q    <= DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            shift_q    <= shift_q >> 1;   // LSB first
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            if (pop) begin
              shift_q <= fifo_dout;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    status_w                         = '0;
    status_w[ST_FULL]                = fifo_full;
    status_w[ST_EMPTY]               = fifo_empty;
    status_w[ST_ACTIVE]              = (state_q != IDLE);
    status_w[ST_OVF]                 = overflow_q;
    status_w[ST_CNT_MSB:ST_CNT_LSB]  = 5'(fifo_count);
  end

  // A STATUS read returns the pre-clear overflow value; a new drop on the
  // same edge wins over the clear so it is never lost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      iobus_in_q <= '0;
    end else begin
      if (drop)
        overflow_q <= 1'b1;
      else if (status_rd)
        overflow_q <= 1'b0;
      busy_q     <= (state_q != IDLE) || !fifo_empty;
      iobus_in_q <= status_hit ? status_w : 32'h0;
    end
  end

  assign TX       = tx_q;
  assign TX_BUSY  = busy_q;
  assign IOBUS_IN = iobus_in_q;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_iobus_uart_tx
// Scoreboard bench: a timeline model predicts FIFO occupancy, overflow,
// frame start times and STATUS words; a negedge monitor decodes TX and
// compares IOBUS_IN / TX_BUSY against the queued expectations.
// ----------------------------------------------------------------------------
module tb_iobus_uart_tx;

  localparam logic [31:0] BASE  = 32'h1100_0100;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam int          DRAIN = FRAME * (DEPTH + 2);

  logic        CLK;
  logic        RST_N;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic        TX;
  logic        TX_BUSY;

  iobus_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .TX         (TX),
    .TX_BUSY    (TX_BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] b;
    int         start;
  } frame_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic probe  = 1'b0;
  logic done   = 1'b0;

  // ---------------- reference model (runs on every rising edge) -----------
  logic [7:0]  mq[$];      // bytes waiting in the transmitter's queue
  frame_t      fq[$];      // frames expected on the line, in order
  logic [31:0] sq[$];      // expected IOBUS_IN after each edge
  int          last_pop  = -1000;
  logic        act       = 1'b0;
  logic        ovf       = 1'b0;
  logic        exp_busy  = 1'b0;
  int          m_sz;
  logic [31:0] m_st;
  logic        m_hit;
  frame_t      m_fr;

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (!RST_N) begin
      mq.delete();
      fq.delete();
      sq.delete();
      last_pop = -1000;
      act      = 1'b0;
      ovf      = 1'b0;
      exp_busy = 1'b0;
    end else begin
      m_sz       = mq.size();
      m_st       = '0;
      m_st[0]    = (m_sz == DEPTH);
      m_st[1]    = (m_sz == 0);
      m_st[2]    = act;
      m_st[3]    = ovf;
      m_st[8:4]  = 5'(m_sz);
      m_hit      = (IOBUS_ADDR == BASE + 32'd4);
      sq.push_back(m_hit ? m_st : 32'h0);
      exp_busy   = act || (m_sz > 0);
      // A new frame can begin one frame-length after the previous one began.
      if (m_sz > 0 && cyc >= last_pop + FRAME) begin
        m_fr.b     = mq.pop_front();
        m_fr.start = cyc + 1;
        fq.push_back(m_fr);
        last_pop   = cyc;
      end
      if (m_hit && !IOBUS_WR) ovf = 1'b0;
      if (IOBUS_WR && IOBUS_ADDR == BASE) begin
        if (mq.size() < DEPTH) mq.push_back(IOBUS_OUT[7:0]);
        else                   ovf = 1'b1;
      end
      act = (cyc < last_pop + FRAME);
    end
  end

  // ---------------- monitor / scoreboard ----------------------------------
  task automatic chk(input string name, input logic [31:0] actv, input logic [31:0] expv);
    checks = checks + 1;
    if (actv !== expv) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", name, actv, expv, cyc);
    end
  endtask

  logic        mon_active = 1'b0;
  int          mon_idx    = 0;
  int          mon_bad    = 0;
  logic [9:0]  mon_bits   = '0;
  logic [7:0]  mon_byte   = '0;
  logic [31:0] mon_exp;
  frame_t      mon_fr;

  always @(negedge CLK or posedge probe) begin
    if (probe) begin
      chk("rst_async_tx",   32'(TX),      32'd1);
      chk("rst_async_busy", 32'(TX_BUSY), 32'd0);
    end else if (!RST_N) begin
      mon_active = 1'b0;
      chk("rst_tx",   32'(TX),      32'd1);
      chk("rst_busy", 32'(TX_BUSY), 32'd0);
      chk("rst_in",   IOBUS_IN,     32'd0);
    end else begin
      if (sq.size() > 0) begin
        mon_exp = sq.pop_front();
        chk("iobus_in", IOBUS_IN, mon_exp);
      end
      chk("tx_busy", 32'(TX_BUSY), 32'(exp_busy));
      if (mon_active) begin
        if (TX !== mon_bits[4'(mon_idx / CPB)]) mon_bad = mon_bad + 1;
        mon_idx = mon_idx + 1;
        if (mon_idx == FRAME) begin
          chk($sformatf("frame_bits_%h", mon_byte), 32'(mon_bad), 32'd0);
          mon_active = 1'b0;
        end
      end else if (fq.size() == 0) begin
        chk("tx_idle", 32'(TX), 32'd1);
      end else if (TX === 1'b0) begin
        mon_fr = fq.pop_front();
        chk($sformatf("start_cycle_%h", mon_fr.b), 32'(cyc), 32'(mon_fr.start));
        mon_byte   = mon_fr.b;
        mon_bits   = {1'b1, mon_fr.b, 1'b0};
        mon_idx    = 1;
        mon_bad    = 0;
        mon_active = 1'b1;
      end else if (cyc > fq[0].start) begin
        mon_fr = fq.pop_front();
        chk($sformatf("start_late_%h", mon_fr.b), 32'(cyc), 32'(mon_fr.start));
      end
      if (done) begin
        chk("frames_left", 32'(fq.size()), 32'd0);
        chk("frame_open",  32'(mon_active), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  // ---------------- stimulus ---------------------------------------------
  task automatic drv(input logic [31:0] a, input logic [31:0] d, input logic w);
    @(negedge CLK);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = w;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(32'h0, 32'h0, 1'b0);
  endtask

  int k;
  int r;

  initial begin
    RST_N      = 1'b0;
    IOBUS_ADDR = '0;
    IOBUS_OUT  = '0;
    IOBUS_WR   = 1'b0;
    repeat (3) @(negedge CLK);
    #1 RST_N = 1'b1;

    // Reset state, then a read at an unrelated address.
    drv(BASE + 32'd4, 32'h0, 1'b0);
    drv(32'h1100_0200, 32'h0, 1'b0);

    // Single byte.
    drv(BASE, 32'hA5, 1'b1);
    idle(45);
    drv(BASE + 32'd4, 32'h0, 1'b0);

    // Back-to-back bytes: second frame follows the first stop bit directly.
    drv(BASE, 32'h00, 1'b1);
    drv(BASE, 32'hFF, 1'b1);
    idle(85);

    // Overflow while a frame is on the line; two reads show set then cleared.
    drv(BASE, 32'h11, 1'b1);
    idle(3);
    for (int i = 0; i < 6; i++) drv(BASE, 32'h20 + i, 1'b1);
    drv(BASE + 32'd4, 32'h0, 1'b0);
    drv(BASE + 32'd4, 32'h0, 1'b0);
    idle(DRAIN);

    // Full FIFO with a push landing on the serializer's pop edge.
    drv(BASE, 32'h3C, 1'b1);
    k = cyc + 1;
    idle(1);
    for (int i = 0; i < 4; i++) drv(BASE, 32'h40 + i, 1'b1);
    while (cyc + 1 < k + FRAME + 1) idle(1);
    drv(BASE, 32'h5A, 1'b1);
    drv(BASE + 32'd4, 32'h0, 1'b0);
    idle(DRAIN);

    // Address decode: stores elsewhere are ignored; reads elsewhere give 0.
    drv(BASE + 32'd8, 32'h77, 1'b1);
    drv(BASE + 32'd4, 32'h66, 1'b1);
    drv(BASE + 32'd4, 32'h0, 1'b0);
    drv(BASE + 32'd8, 32'h0, 1'b0);
    drv(BASE, 32'h0, 1'b0);
    idle(50);

    // Randomised traffic mix.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: drv(BASE, $urandom, 1'b1);
        4, 5, 6:    drv(BASE + 32'd4, $urandom, 1'($urandom_range(0, 1)));
        7:          drv(BASE + 32'd8, $urandom, 1'b1);
        8:          drv($urandom, $urandom, 1'($urandom_range(0, 1)));
        default:    idle(1);
      endcase
    end
    idle(DRAIN);

    // Reset in the middle of data bit 3 (a zero bit of 8'h37).
    drv(BASE, 32'h37, 1'b1);
    k = cyc + 1;
    while (cyc < k + 19) idle(1);
    #1 RST_N = 1'b0;
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    repeat (2) @(negedge CLK);
    #1 RST_N = 1'b1;
    drv(BASE + 32'd4, 32'h0, 1'b0);
    idle(60);

    done = 1'b1;
    repeat (4) @(negedge CLK);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
